// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the instruction-queue entry format.
// Used by if_id_queue and its storage sub-module.
package lc3b_types;

  // Native 16-bit machine word of the LC-3b.
  typedef logic [15:0] lc3b_word;

  // One queued fetch result: the instruction and the address it came from.
  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } lc3b_ifq_entry;

  // Default number of entries in the fetch/decode queue.
  localparam int IFQ_DEPTH_DEFAULT = 4;

  // Width of one packed queue entry, handy for flat storage ports.
  localparam int IFQ_ENTRY_W = $bits(lc3b_ifq_entry);

  // Sequential next-PC; wraps naturally at the top of the address space.
  function automatic lc3b_word lc3b_next_pc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_queue_storage.sv
// ifq_storage: DEPTH-entry register array for the fetch/decode queue.
// One synchronous write port, one asynchronous read port.
// Reset clears every entry so no stale instruction survives a reset.
module ifq_storage
  import lc3b_types::*;
#(
  parameter  int DEPTH = IFQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [PTR_W-1:0]       waddr,
  input  logic [IFQ_ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]       raddr,
  output logic [IFQ_ENTRY_W-1:0] rdata
);

  lc3b_ifq_entry r_mem [DEPTH];

  // Write port: clear everything on reset, otherwise store one entry when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= lc3b_ifq_entry'(wdata);
    end
  end

  // Read port is purely combinational so the head is visible without extra latency.
  assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: instruction queue between LC-3b fetch and decode.
// Holds {PC, instruction} pairs in FIFO order so fetch keeps running while
// decode stalls. flush (redirect) and reset empty the queue in one cycle.
// Optional macro IFQ_BYPASS_EN adds a zero-latency path from enq_* to deq_*
// when the queue is empty; without it the queue always has one cycle latency
// and no combinational path from enq_* to deq_*.
module if_id_queue
  import lc3b_types::*;
#(
  parameter  int DEPTH = IFQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [15:0]      enq_pc,
  input  logic [15:0]      enq_instr,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [15:0]      deq_pc,
  output logic [15:0]      deq_npc,
  output logic [15:0]      deq_instr,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [PTR_W:0]         r_count;

  logic [IFQ_ENTRY_W-1:0] w_rdata;
  logic [IFQ_ENTRY_W-1:0] w_wdata;
  lc3b_ifq_entry          w_head_entry;
  lc3b_ifq_entry          w_enq_entry;

  logic                   w_stored_valid;
  logic                   w_enq_ready;
  logic                   w_enq_fire;
  logic                   w_bypass_take;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_we;
  logic                   w_deq_valid;
  lc3b_word               w_deq_pc;
  lc3b_word               w_deq_instr;

  assign w_enq_entry.pc    = enq_pc;
  assign w_enq_entry.instr = enq_instr;
  assign w_wdata           = w_enq_entry;
  assign w_head_entry      = lc3b_ifq_entry'(w_rdata);

  // Full test only looks at occupancy, never at deq_ready, so decode cannot
  // reach back into fetch combinationally. A full queue refuses an offer even
  // when the head leaves in the same cycle.
  assign w_stored_valid = (r_count != '0);
  assign w_enq_ready    = (r_count != FULL_COUNT);
  assign w_enq_fire     = enq_valid && w_enq_ready;

  // Select what decode sees: normally the stored head, or with the bypass
  // build the incoming fetch result while the queue is empty.
  always_comb begin
    w_deq_valid   = w_stored_valid;
    w_deq_pc      = w_head_entry.pc;
    w_deq_instr   = w_head_entry.instr;
    w_bypass_take = 1'b0;
`ifdef IFQ_BYPASS_EN
    if (!w_stored_valid && !flush && !reset) begin
      w_deq_valid   = enq_valid;
      w_deq_pc      = enq_pc;
      w_deq_instr   = enq_instr;
      w_bypass_take = enq_valid && deq_ready;
    end
`endif
  end

  // An entry handed straight to decode is never written; a pop only ever
  // removes something that was actually stored.
  assign w_push = w_enq_fire && !w_bypass_take;
  assign w_pop  = w_stored_valid && deq_ready;
  assign w_we   = w_push && !flush && !reset;

  // Pointer and occupancy bookkeeping; flush and reset win over any traffic.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (r_tail),
    .wdata (w_wdata),
    .raddr (r_head),
    .rdata (w_rdata)
  );

  // Outputs are forced to zero whenever nothing valid is presented.
  assign enq_ready = w_enq_ready;
  assign deq_valid = w_deq_valid;
  assign deq_pc    = w_deq_valid ? w_deq_pc : 16'h0000;
  assign deq_instr = w_deq_valid ? w_deq_instr : 16'h0000;
  assign deq_npc   = w_deq_valid ? lc3b_next_pc(w_deq_pc) : 16'h0000;
  assign count     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a table of directed vectors followed
// by hand-written sequences for pointer wrap and the bypass path.
module tb_if_id_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [15:0] enq_pc;
  logic [15:0] enq_instr;
  logic        enq_ready;
  logic        deq_valid;
  logic [15:0] deq_pc;
  logic [15:0] deq_npc;
  logic [15:0] deq_instr;
  logic        deq_ready;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_npc   (deq_npc),
    .deq_instr (deq_instr),
    .deq_ready (deq_ready),
    .count     (count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] ein;
    logic        dr;
    logic        er;
    logic        dv;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] ins;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic ev,
                              input logic [15:0] epc, input logic [15:0] ein,
                              input logic dr, input logic er, input logic dv,
                              input logic [15:0] pc, input logic [15:0] npc,
                              input logic [15:0] ins, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ev = ev; v.epc = epc; v.ein = ein; v.dr = dr;
    v.er = er; v.dv = dv; v.pc = pc; v.npc = npc; v.ins = ins; v.cnt = cnt;
    return v;
  endfunction

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs away from the active edge.
  task automatic applyStimulus(input logic rst, input logic fl, input logic ev,
                               input logic [15:0] epc, input logic [15:0] ein,
                               input logic dr);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    enq_valid = ev;
    enq_pc    = epc;
    enq_instr = ein;
    deq_ready = dr;
    #1;
  endtask

  initial begin
    vec_t v;
    logic [15:0] mq[$];
    logic [15:0] expPc;
    logic        expValid;
    logic        enqFire;
    logic        deqFire;
    logic        bypassTake;
    int          offered;
    int          received;
    int          cyc;

    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0; deq_ready = 1'b0;
    repeat (2) @(posedge clk);

    //         rst fl ev epc       ein       dr  er dv pc        npc       ins       cnt
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 1, 16'h3000, 16'h1234, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 1, 16'h3002, 16'h5678, 0,  1, 1, 16'h3000, 16'h3002, 16'h1234, 3'd1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 1, 16'h3000, 16'h3002, 16'h1234, 3'd2));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1,  1, 1, 16'h3000, 16'h3002, 16'h1234, 3'd2));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1,  1, 1, 16'h3002, 16'h3004, 16'h5678, 3'd1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    // fill to full, then refuse a fifth offer even while the head leaves
    vecs.push_back(mk(0, 0, 1, 16'h3000, 16'hA000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 1, 16'h3002, 16'hA001, 0,  1, 1, 16'h3000, 16'h3002, 16'hA000, 3'd1));
    vecs.push_back(mk(0, 0, 1, 16'h3004, 16'hA002, 0,  1, 1, 16'h3000, 16'h3002, 16'hA000, 3'd2));
    vecs.push_back(mk(0, 0, 1, 16'h3006, 16'hA003, 0,  1, 1, 16'h3000, 16'h3002, 16'hA000, 3'd3));
    vecs.push_back(mk(0, 0, 1, 16'h3008, 16'hA004, 0,  0, 1, 16'h3000, 16'h3002, 16'hA000, 3'd4));
    vecs.push_back(mk(0, 0, 1, 16'h3008, 16'hA004, 1,  0, 1, 16'h3000, 16'h3002, 16'hA000, 3'd4));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 1, 16'h3002, 16'h3004, 16'hA001, 3'd3));
    // flush with an offer pending: everything disappears, then 0x4000 is first out
    vecs.push_back(mk(0, 1, 1, 16'h3100, 16'hBEEF, 0,  1, 1, 16'h3002, 16'h3004, 16'hA001, 3'd3));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 1, 16'h4000, 16'h4444, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1,  1, 1, 16'h4000, 16'h4002, 16'h4444, 3'd1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    // next-PC wraps at the top of memory
    vecs.push_back(mk(0, 0, 1, 16'hFFFE, 16'h7777, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1,  1, 1, 16'hFFFE, 16'h0000, 16'h7777, 3'd1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    // reset mid-stream
    vecs.push_back(mk(0, 0, 1, 16'h5000, 16'h1111, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mk(0, 0, 1, 16'h5002, 16'h2222, 0,  1, 1, 16'h5000, 16'h5002, 16'h1111, 3'd1));
    vecs.push_back(mk(1, 0, 1, 16'h5004, 16'h3333, 0,  1, 1, 16'h5000, 16'h5002, 16'h1111, 3'd2));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0));

    foreach (vecs[i]) begin
      v = vecs[i];
`ifdef IFQ_BYPASS_EN
      if (v.cnt == 3'd0 && v.ev && !v.fl && !v.rst) begin
        v.dv  = 1'b1;
        v.pc  = v.epc;
        v.npc = v.epc + 16'd2;
        v.ins = v.ein;
      end
`endif
      applyStimulus(v.rst, v.fl, v.ev, v.epc, v.ein, v.dr);
      checkOutput($sformatf("vec%0d enq_ready", i), {15'd0, enq_ready}, {15'd0, v.er});
      checkOutput($sformatf("vec%0d deq_valid", i), {15'd0, deq_valid}, {15'd0, v.dv});
      checkOutput($sformatf("vec%0d deq_pc", i), deq_pc, v.pc);
      checkOutput($sformatf("vec%0d deq_npc", i), deq_npc, v.npc);
      checkOutput($sformatf("vec%0d deq_instr", i), deq_instr, v.ins);
      checkOutput($sformatf("vec%0d count", i), {13'd0, count}, {13'd0, v.cnt});
    end

    // 10 entries through with an irregular decode pattern so pointers wrap twice.
    offered  = 0;
    received = 0;
    cyc      = 0;
    while (received < 10 && cyc < 80) begin
      applyStimulus(1'b0, 1'b0, offered < 10, 16'h6000 + 16'(offered * 2),
                    ~(16'h6000 + 16'(offered * 2)), (cyc % 3) != 2);
      expValid   = (mq.size() != 0);
      expPc      = expValid ? mq[0] : 16'h0000;
      bypassTake = 1'b0;
`ifdef IFQ_BYPASS_EN
      if (mq.size() == 0 && enq_valid) begin
        expValid   = 1'b1;
        expPc      = enq_pc;
        bypassTake = deq_ready;
      end
`endif
      checkOutput("wrap enq_ready", {15'd0, enq_ready}, {15'd0, mq.size() < 4});
      checkOutput("wrap deq_valid", {15'd0, deq_valid}, {15'd0, expValid});
      checkOutput("wrap deq_pc", deq_pc, expPc);
      checkOutput("wrap deq_instr", deq_instr, expValid ? ~expPc : 16'h0000);
      enqFire = enq_valid && (mq.size() < 4);
      deqFire = expValid && deq_ready;
      if (deqFire) received++;
      if (deqFire && !bypassTake) void'(mq.pop_front());
      if (enqFire && !bypassTake) mq.push_back(enq_pc);
      if (enqFire) offered++;
      cyc++;
    end
    checkOutput("wrap all delivered", 16'(received), 16'd10);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("wrap drained count", {13'd0, count}, 16'd0);

`ifdef IFQ_BYPASS_EN
    // Empty queue with decode ready: the entry goes straight through.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h3010, 16'hC0DE, 1'b1);
    checkOutput("bypass deq_valid", {15'd0, deq_valid}, 16'd1);
    checkOutput("bypass deq_pc", deq_pc, 16'h3010);
    checkOutput("bypass deq_instr", deq_instr, 16'hC0DE);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("bypass count", {13'd0, count}, 16'd0);
    checkOutput("bypass after valid", {15'd0, deq_valid}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
